// File: rtl/s_axi4l_regfile.sv
// AXI4-Lite register bank: CTRL / STATUS / IRQ_STAT (W1C) / CNT with maskable interrupt.
// Optional read-to-clear of IRQ_STAT when S_AXI4L_REGFILE_RDCLR_EN is defined.
module s_axi4l_regfile #(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ADDR_WIDTH = 4,
  parameter int          AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
  parameter int          IRQ_WIDTH      = 8,
  parameter logic [31:0] CTRL_RESET     = 32'h0
) (
  input  logic                      i_axi_clock,
  input  logic                      i_axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] i_waddr,
  input  logic [AXI_DATA_WIDTH-1:0] i_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] i_wstrb,
  input  logic                      i_wvalid,
  input  logic [AXI_ADDR_WIDTH-1:0] i_raddr,
  input  logic                      i_raddr_valid,
  output logic [AXI_DATA_WIDTH-1:0] o_rdata,
  input  logic [31:0]               i_status,
  input  logic [IRQ_WIDTH-1:0]      i_irq_set,
  output logic [31:0]               o_ctrl,
  output logic [31:0]               o_cnt,
  output logic                      o_irq
);

  localparam logic [1:0] A_CTRL = 2'd0, A_STAT = 2'd1, A_IRQ = 2'd2, A_CNT = 2'd3;

  logic [31:0]          r_ctrl, r_cnt;
  logic [IRQ_WIDTH-1:0] r_irq_stat;

  logic [1:0]           w_wsel, w_rsel;
  logic [31:0]          w_bmask;
  logic [IRQ_WIDTH-1:0] w_clr_w1c, w_clr;
  logic                 w_wr_ctrl, w_wr_irq, w_wr_cnt;
  logic                 w_unused;

  assign w_wsel    = i_waddr[3:2];
  assign w_rsel    = i_raddr[3:2];
  assign w_wr_ctrl = i_wvalid & (w_wsel == A_CTRL);
  assign w_wr_irq  = i_wvalid & (w_wsel == A_IRQ);
  assign w_wr_cnt  = i_wvalid & (w_wsel == A_CNT);
  assign w_unused  = ^{i_waddr[1:0], i_raddr[1:0]};

  // Expand byte strobes into a bit mask for read-modify-write merges
  for (genvar k = 0; k < 4; k++) begin : g_bmask
    assign w_bmask[8*k +: 8] = {8{i_wstrb[k]}};
  end

  for (genvar n = 0; n < IRQ_WIDTH; n++) begin : g_clr
    assign w_clr_w1c[n] = w_wr_irq & i_wstrb[n/8] & i_wdata[n];
  end

`ifdef S_AXI4L_REGFILE_RDCLR_EN
  logic w_rdclr;
  assign w_rdclr = i_raddr_valid & (w_rsel == A_IRQ);
  assign w_clr   = w_clr_w1c | {IRQ_WIDTH{w_rdclr}};
`else
  assign w_clr   = w_clr_w1c;
`endif

  always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      r_ctrl     <= CTRL_RESET;
      r_cnt      <= '0;
      r_irq_stat <= '0;
    end else begin
      if (w_wr_ctrl)
        r_ctrl <= (r_ctrl & ~w_bmask) | (i_wdata & w_bmask);
      // A CNT write freezes unstrobed bytes rather than letting them increment
      if (w_wr_cnt)
        r_cnt <= (r_cnt & ~w_bmask) | (i_wdata & w_bmask);
      else if (r_ctrl[0])
        r_cnt <= r_cnt + 32'd1;
      r_irq_stat <= (r_irq_stat & ~w_clr) | i_irq_set;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_raddr_valid) begin
      case (w_rsel)
        A_CTRL:  o_rdata = r_ctrl;
        A_STAT:  o_rdata = i_status;
        A_IRQ:   o_rdata = {{(32-IRQ_WIDTH){1'b0}}, r_irq_stat};
        default: o_rdata = r_cnt;
      endcase
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_cnt  = r_cnt;
  assign o_irq  = |(r_irq_stat & r_ctrl[8 +: IRQ_WIDTH]);

endmodule
